audio_data_serdes: RTL

//  FPGA-side WM8731 digital audio port, codec in slave mode. Generates mclk/bclk/daclrc/adclrc from clk.

---
 rtl/audio_data_serdes_pkg.sv | 14 +
 rtl/audio_bclk_gen.sv | 98 +++++++++
 rtl/audio_data_serdes.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/audio_data_serdes_pkg.sv
// Shared definitions for the WM8731 audio serdes: FSM state encoding,
// default frame width and the LR-clock level that marks the left channel.
package audio_data_serdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } serdes_state_e;

    localparam int   DEFAULT_WIDTH = 32;
    localparam logic LRC_LEFT      = 1'b1;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: bclk divider, rise/fall strobes, frame bit counter and LR clock.
// Strobes are combinational so the datapath updates on the same clk edge as bclk.
module audio_bclk_gen
    import audio_data_serdes_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic stop_i,
    output logic bclk_o,
    output logic lrc_o,
    output logic fall_o,
    output logic frame_start_o,
    output logic frame_end_o,
    output logic sample_o,
    output logic sample_last_o
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(WIDTH / 2);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d, bit_inc;
    logic          bclk_q, bclk_d;
    logic          lrc_q, lrc_d;
    logic          primed_q, primed_d;
    logic          term, rise, wrap;

    assign term          = run_i && (div_q == DIV_LAST);
    assign rise          = term && !bclk_q;
    assign fall_o        = term && bclk_q;
    assign wrap          = fall_o && (bit_q == BIT_LAST);
    assign frame_start_o = wrap && !stop_i;
    assign frame_end_o   = wrap && stop_i;
    // The first rise after leaving IDLE precedes any frame; primed_q masks it.
    assign sample_o      = rise && primed_q;
    assign sample_last_o = sample_o && (bit_q == BIT_LAST);
    assign bit_inc       = bit_q + 1'b1;

    assign bclk_o = bclk_q;
    assign lrc_o  = lrc_q;

    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        bclk_d   = bclk_q;
        lrc_d    = lrc_q;
        primed_d = primed_q;
        if (!run_i || frame_end_o) begin
            // Parking bit_q at the last bit makes the next fall wrap to a frame start.
            div_d    = '0;
            bit_d    = BIT_LAST;
            bclk_d   = 1'b0;
            lrc_d    = 1'b0;
            primed_d = 1'b0;
        end else begin
            div_d = term ? '0 : div_q + 1'b1;
            if (term) begin
                bclk_d = !bclk_q;
            end
            if (fall_o) begin
                if (bit_q == BIT_LAST) begin
                    bit_d    = '0;
                    lrc_d    = LRC_LEFT;
                    primed_d = 1'b1;
                end else begin
                    bit_d = bit_inc;
                    if (bit_inc == BIT_HALF) begin
                        lrc_d = !LRC_LEFT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            bit_q    <= BIT_LAST;
            bclk_q   <= 1'b0;
            lrc_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrc_q    <= lrc_d;
            primed_q <= primed_d;
        end
    end

endmodule

// File: rtl/audio_data_serdes.sv
// WM8731 slave-mode audio port: clock generation, left-justified tx/rx serdes.
// Build option AUDIO_SERDES_LOOPBACK_EN routes internal dacdat into the rx shifter.
module audio_data_serdes
    import audio_data_serdes_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int BCLK_DIV = 4,
    parameter int MCLK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underflow,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             mclk,
    output logic             bclk,
    output logic             daclrc,
    output logic             dacdat,
    output logic             adclrc,
    input  logic             adcdat,
    output serdes_state_e    state_dbg
);

    // tx handshake: a word moves into the holding register on any clk where
    // tx_valid && tx_ready; tx_ready stays low until a frame start consumes it.

    localparam int MW = $clog2(MCLK_DIV + 1);
    localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);

    serdes_state_e    state_q, state_d;
    logic [MW-1:0]    mclk_cnt_q, mclk_cnt_d;
    logic             mclk_q, mclk_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic run, stop, lrc, fall, frame_start, frame_end, sample, sample_last;
    logic rx_bit;

    assign run  = (state_q != ST_IDLE);
    assign stop = (state_q == ST_DRAIN) && !enable;

    audio_bclk_gen #(
        .WIDTH    (WIDTH),
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk           (clk),
        .reset         (reset),
        .run_i         (run),
        .stop_i        (stop),
        .bclk_o        (bclk),
        .lrc_o         (lrc),
        .fall_o        (fall),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end),
        .sample_o      (sample),
        .sample_last_o (sample_last)
    );

`ifdef AUDIO_SERDES_LOOPBACK_EN
    assign rx_bit = tx_shift_q[WIDTH-1];
`else
    assign rx_bit = adcdat;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mclk_cnt_d  = mclk_cnt_q + 1'b1;
        mclk_d      = mclk_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        underflow_d = 1'b0;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;

        if (mclk_cnt_q == MCLK_LAST) begin
            mclk_cnt_d = '0;
            mclk_d     = !mclk_q;
        end

        if (!run || frame_end) begin
            tx_shift_d = '0;
        end else if (frame_start) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d  = '0;
                underflow_d = 1'b1;
            end
        end else if (fall) begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end

        // A word arriving on an underflowing frame start is kept for the next frame.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (sample) begin
            rx_shift_d = {rx_shift_q[WIDTH-3:0], rx_bit};
        end
        if (sample_last) begin
            rx_data_d  = {rx_shift_q, rx_bit};
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mclk_cnt_q  <= '0;
            mclk_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            underflow_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mclk_cnt_q  <= mclk_cnt_d;
            mclk_q      <= mclk_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            underflow_q <= underflow_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign tx_ready     = !hold_full_q;
    assign tx_underflow = underflow_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign mclk         = mclk_q;
    assign daclrc       = lrc;
    assign adclrc       = lrc;
    assign dacdat       = tx_shift_q[WIDTH-1];
    assign state_dbg    = state_q;

endmodule
